alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/add ops plus a WIDTH-cycle shift-add multiplier,
// with valid/ready handshakes on both sides and a registered result with flags.
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             ov,
    output logic             busy
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplr_q, mplr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              no_q, no_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              zr_q, zr_d;
    logic              ng_q, ng_d;
    logic              ov_q, ov_d;

    logic [WIDTH-1:0]  xz, xp, yz, yp, sum, r0, res0, low1, res1;
    logic              ov0, ov1, accept;
    logic [PW-1:0]     acc_step;

    // Operand preprocessing and the single-cycle result path
    always_comb begin
        xz   = zx ? '0 : x;
        xp   = nx ? ~xz : xz;
        yz   = zy ? '0 : y;
        yp   = ny ? ~yz : yz;
        sum  = xp + yp;
        r0   = f ? sum : (xp & yp);
        res0 = no ? ~r0 : r0;
        ov0  = f & (xp[WIDTH-1] == yp[WIDTH-1]) & (sum[WIDTH-1] != xp[WIDTH-1]);
    end

    // One shift-add multiplier step; the last step's sum is the full product
    always_comb begin
        acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);
        low1     = acc_step[WIDTH-1:0];
        res1     = no_q ? ~low1 : low1;
        ov1      = |acc_step[PW-1:WIDTH];
    end

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplr_d      = mplr_q;
        cnt_d       = cnt_q;
        no_d        = no_q;
        out_d       = out_q;
        zr_d        = zr_q;
        ng_d        = ng_q;
        ov_d        = ov_q;
        out_valid_d = out_valid_q && !out_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!mode) begin
                        out_d       = res0;
                        zr_d        = (res0 == '0);
                        ng_d        = res0[WIDTH-1];
                        ov_d        = ov0;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = MUL;
                        acc_d   = '0;
                        mcand_d = {{WIDTH{1'b0}}, xp};
                        mplr_d  = yp;
                        cnt_d   = '0;
                        no_d    = no;
                    end
                end
            end
            MUL: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = IDLE;
                    out_d       = res1;
                    zr_d        = (res1 == '0);
                    ng_d        = res1[WIDTH-1];
                    ov_d        = ov1;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            cnt_q       <= '0;
            no_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zr_q        <= 1'b1;
            ng_q        <= 1'b0;
            ov_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplr_q      <= mplr_d;
            cnt_q       <= cnt_d;
            no_q        <= no_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            zr_q        <= zr_d;
            ng_q        <= ng_d;
            ov_q        <= ov_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign ov        = ov_q;
    assign busy      = (state_q == MUL);

endmodule
